cpu_bus_responder: RTL and testbench

//  Bus-side responder for the 6502 core (U7). Replaces the ad-hoc address decode in the top level.
//  - Samples each CPU bus cycle (address, write enable, write data).
//  - Forwards the cycle to the PSRAM memory controller (memCtrl) through its CE/busy handshake.
//  - Stalls the CPU via RDY until the access completes, then returns read data on DI.
//  - Captures writes to the VIC border-colour register for the video path.

---
 rtl/cpu_bus_responder.sv | 201 ++++++++++++++++++++
 tb/tb_cpu_bus_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_responder.sv
// ============================================================================
//  Module   : cpu_bus_responder
//  Purpose  : Bus-side responder for the 6502 core. Samples each CPU bus
//             cycle, forwards it to the PSRAM controller through its
//             CE/busy handshake, stalls the CPU via RDY until the access
//             completes, and captures writes to the VIC border-colour
//             register for the video path.
//  Options  : BOOT_VECTOR_EN - when defined, reads of 16'hFFFC/16'hFFFD are
//             answered locally from BOOT_VECTOR without touching memory.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_bus_responder #(
  parameter int unsigned TIMEOUT     = 64,
  parameter logic [15:0] BORDER_ADDR = 16'hD020
`ifdef BOOT_VECTOR_EN
  // The local reset vector only exists when the local decode is built.
  , parameter logic [15:0] BOOT_VECTOR = 16'hC000
`endif
) (
  input  logic        clk,
  input  logic        reset,
  // CPU side
  input  logic [15:0] cpu_ab,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_we,
  output logic [7:0]  cpu_di,
  output logic        cpu_rdy,
  // Memory controller side
  output logic        mem_ce,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [3:0]  mem_nbytes,
  output logic [7:0]  mem_wdata,
  input  logic        mem_busy,
  input  logic [7:0]  mem_rdata,
  // Side outputs
  output logic [3:0]  border_color,
  output logic        bus_err
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // The counter only has to reach TIMEOUT-1: the WAIT cycle that sees that
  // value is the TIMEOUT-th one and is the last before the access is dropped.
  localparam int unsigned       CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]       state_q,  state_d;
  logic [15:0]      addr_q,   addr_d;
  logic             write_q,  write_d;
  logic [7:0]       wdata_q,  wdata_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             seen_q,   seen_d;
  logic [7:0]       di_q,     di_d;
  logic [3:0]       border_q, border_d;
  logic             err_q,    err_d;

  logic             complete;
  logic             expired;
  logic             border_hit;

`ifdef BOOT_VECTOR_EN
  logic             boot_hit;

  // Only reads of the reset vector pair are served locally; writes go out.
  always_comb begin
    boot_hit = !cpu_we && ((cpu_ab == 16'hFFFC) || (cpu_ab == 16'hFFFD));
  end
`endif

  // Handshake status and border decode for the access held in the registers.
  always_comb begin
    complete   = seen_q && !mem_busy;
    expired    = (cnt_q == CNT_LAST);
    border_hit = write_q && (addr_q == BORDER_ADDR);
  end

  // Next-state logic: sample, strobe, wait for busy to fall (or give up), ack.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    seen_d   = seen_q;
    di_d     = di_q;
    border_d = border_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        addr_d  = cpu_ab;
        write_d = cpu_we;
        wdata_d = cpu_do;
        state_d = ST_ISSUE;
`ifdef BOOT_VECTOR_EN
        if (boot_hit) begin
          di_d    = cpu_ab[0] ? BOOT_VECTOR[15:8] : BOOT_VECTOR[7:0];
          state_d = ST_DONE;
        end
`endif
      end

      ST_ISSUE: begin
        // A busy left high by the previous access already counts as seen,
        // so the handshake does not need a second strobe to make progress.
        cnt_d   = '0;
        seen_d  = mem_busy;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        cnt_d  = cnt_q + CNT_ONE;
        seen_d = seen_q | mem_busy;
        if (complete) begin
          // Completion takes priority over a timeout on the same edge.
          if (!write_q) begin
            di_d = mem_rdata;
          end
          if (border_hit) begin
            border_d = wdata_q[3:0];
          end
          state_d = ST_DONE;
        end else if (expired) begin
          // Abandoned access: flag it, return a recognisable filler byte to
          // a read, and still honour a border write (no retry is attempted).
          err_d = 1'b1;
          if (!write_q) begin
            di_d = 8'hFF;
          end
          if (border_hit) begin
            border_d = wdata_q[3:0];
          end
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= 16'h0000;
      write_q  <= 1'b0;
      wdata_q  <= 8'h00;
      cnt_q    <= '0;
      seen_q   <= 1'b0;
      di_q     <= 8'h00;
      border_q <= 4'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      di_q     <= di_d;
      border_q <= border_d;
      err_q    <= err_d;
    end
  end

  // Output mapping: strobe and ready are pure state decodes, so each lasts
  // exactly one cycle and both drop immediately when reset is asserted.
  always_comb begin
    mem_ce       = (state_q == ST_ISSUE);
    cpu_rdy      = (state_q == ST_DONE);
    mem_write    = write_q;
    mem_addr     = addr_q;
    mem_wdata    = wdata_q;
    mem_nbytes   = 4'd1;
    cpu_di       = di_q;
    border_color = border_q;
    bus_err      = err_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_bus_responder.sv
// ============================================================================
//  Module   : tb_cpu_bus_responder
//  Purpose  : Directed, table-driven bench for cpu_bus_responder with a small
//             cycle-level memory-controller model. Expectations depend on
//             BOOT_VECTOR_EN for the reset-vector reads.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_bus_responder;

  localparam int unsigned TO  = 64;
  localparam int          NV  = 17;

  logic        clk;
  logic        reset;
  logic [15:0] cpu_ab;
  logic [7:0]  cpu_do;
  logic        cpu_we;
  logic [7:0]  cpu_di;
  logic        cpu_rdy;
  logic        mem_ce;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [3:0]  mem_nbytes;
  logic [7:0]  mem_wdata;
  logic        mem_busy;
  logic [7:0]  mem_rdata;
  logic [3:0]  border_color;
  logic        bus_err;

  int checks;
  int errors;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          bcyc;      // cycles busy stays high after the strobe
    bit          stale;     // busy already high during the strobe cycle
    logic [7:0]  rdata;
    logic [7:0]  exp_di;
    logic [3:0]  exp_border;
    int          exp_lat;   // cycles from the IDLE cycle to the RDY cycle
    int          exp_ce;
    logic        exp_err;
  } vec_t;

  vec_t vecs [NV];

  cpu_bus_responder #(
    .TIMEOUT     (TO),
    .BORDER_ADDR (16'hD020)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_ab       (cpu_ab),
    .cpu_do       (cpu_do),
    .cpu_we       (cpu_we),
    .cpu_di       (cpu_di),
    .cpu_rdy      (cpu_rdy),
    .mem_ce       (mem_ce),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_nbytes   (mem_nbytes),
    .mem_wdata    (mem_wdata),
    .mem_busy     (mem_busy),
    .mem_rdata    (mem_rdata),
    .border_color (border_color),
    .bus_err      (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                              input int bcyc, input bit stale, input logic [7:0] rdata,
                              input logic [7:0] exp_di, input logic [3:0] exp_border,
                              input int exp_lat, input int exp_ce, input logic exp_err);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.bcyc = bcyc; v.stale = stale;
    v.rdata = rdata; v.exp_di = exp_di; v.exp_border = exp_border;
    v.exp_lat = exp_lat; v.exp_ce = exp_ce; v.exp_err = exp_err;
    return v;
  endfunction

  // Entered and left at a falling edge in the responder's IDLE cycle.
  // Busy for a given cycle is driven at that cycle's falling edge; the model
  // raises it in the cycle after the strobe and holds it bcyc cycles.
  task automatic run_access(input vec_t v, output int lat, output int ce_cnt, output int ce_at,
                            output logic cap_we, output logic [15:0] cap_addr,
                            output logic [7:0] cap_wd, output logic rdy_after);
    int  pending;
    bit  done;
    pending = 0; done = 0; lat = -1; ce_cnt = 0; ce_at = 0;
    cap_we = 1'bx; cap_addr = 'x; cap_wd = 'x;
    cpu_we = v.we; cpu_ab = v.addr; cpu_do = v.wdata; mem_rdata = v.rdata;
    for (int n = 1; n <= 200 && !done; n++) begin
      @(negedge clk);
      if (pending > 0) begin
        mem_busy = 1'b1;
        pending--;
      end else begin
        mem_busy = 1'b0;
      end
      if (mem_ce) begin
        ce_cnt++;
        if (ce_at == 0) ce_at = n;
        cap_we = mem_write; cap_addr = mem_addr; cap_wd = mem_wdata;
        pending = v.bcyc;
        if (v.stale) mem_busy = 1'b1;
      end
      if (cpu_rdy) begin
        lat  = n;
        done = 1;
      end
    end
    @(negedge clk);
    mem_busy  = 1'b0;
    rdy_after = cpu_rdy;
  endtask

  task automatic apply_vec(input int i);
    int          lat, ce_cnt, ce_at;
    logic        cap_we, rdy_after;
    logic [15:0] cap_addr;
    logic [7:0]  cap_wd;
    run_access(vecs[i], lat, ce_cnt, ce_at, cap_we, cap_addr, cap_wd, rdy_after);
    chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
    chk($sformatf("v%0d_ce_count", i), ce_cnt, vecs[i].exp_ce);
    chk($sformatf("v%0d_rdy_one_cycle", i), {31'd0, rdy_after}, 32'd0);
    chk($sformatf("v%0d_cpu_di", i), {24'd0, cpu_di}, {24'd0, vecs[i].exp_di});
    chk($sformatf("v%0d_border", i), {28'd0, border_color}, {28'd0, vecs[i].exp_border});
    chk($sformatf("v%0d_bus_err", i), {31'd0, bus_err}, {31'd0, vecs[i].exp_err});
    if (vecs[i].exp_ce != 0) begin
      chk($sformatf("v%0d_ce_position", i), ce_at, 1);
      chk($sformatf("v%0d_mem_write", i), {31'd0, cap_we}, {31'd0, vecs[i].we});
      chk($sformatf("v%0d_mem_addr", i), {16'd0, cap_addr}, {16'd0, vecs[i].addr});
      if (vecs[i].we)
        chk($sformatf("v%0d_mem_wdata", i), {24'd0, cap_wd}, {24'd0, vecs[i].wdata});
    end
  endtask

  initial begin
    bit saw_ce;
    checks = 0;
    errors = 0;

    //            we    addr      wdata  bcyc  stl rdata  exp_di brd   lat     ce err
    vecs[0]  = mk(1'b0, 16'h0100, 8'h00, 1,    0, 8'h6B, 8'h6B, 4'h0, 4,      1, 1'b0);
    vecs[1]  = mk(1'b0, 16'h1234, 8'h00, 3,    0, 8'hA5, 8'hA5, 4'h0, 6,      1, 1'b0);
    vecs[2]  = mk(1'b1, 16'hD020, 8'h0E, 2,    0, 8'h33, 8'hA5, 4'hE, 5,      1, 1'b0);
    vecs[3]  = mk(1'b0, 16'h0010, 8'h00, 1,    0, 8'h3C, 8'h3C, 4'hE, 4,      1, 1'b0);
    vecs[4]  = mk(1'b1, 16'hD021, 8'h07, 1,    0, 8'h44, 8'h3C, 4'hE, 4,      1, 1'b0);
    vecs[5]  = mk(1'b0, 16'h2000, 8'h00, 0,    1, 8'h5A, 8'h5A, 4'hE, 3,      1, 1'b0);
    vecs[6]  = mk(1'b0, 16'h3000, 8'h00, TO-1, 0, 8'h77, 8'h77, 4'hE, TO+2,   1, 1'b0);
    vecs[7]  = mk(1'b0, 16'h3001, 8'h00, TO-2, 0, 8'h88, 8'h88, 4'hE, TO+1,   1, 1'b0);
`ifdef BOOT_VECTOR_EN
    vecs[8]  = mk(1'b0, 16'hFFFC, 8'h00, 1,    0, 8'h11, 8'h00, 4'hE, 1,      0, 1'b0);
    vecs[9]  = mk(1'b0, 16'hFFFD, 8'h00, 1,    0, 8'h22, 8'hC0, 4'hE, 1,      0, 1'b0);
    vecs[10] = mk(1'b1, 16'hFFFC, 8'h99, 1,    0, 8'h55, 8'hC0, 4'hE, 4,      1, 1'b0);
`else
    vecs[8]  = mk(1'b0, 16'hFFFC, 8'h00, 1,    0, 8'h11, 8'h11, 4'hE, 4,      1, 1'b0);
    vecs[9]  = mk(1'b0, 16'hFFFD, 8'h00, 1,    0, 8'h22, 8'h22, 4'hE, 4,      1, 1'b0);
    vecs[10] = mk(1'b1, 16'hFFFC, 8'h99, 1,    0, 8'h55, 8'h22, 4'hE, 4,      1, 1'b0);
`endif
    vecs[11] = mk(1'b0, 16'h4000, 8'h00, 0,    0, 8'h12, 8'hFF, 4'hE, TO+2,   1, 1'b1);
    vecs[12] = mk(1'b1, 16'hD020, 8'h05, 0,    0, 8'h12, 8'hFF, 4'h5, TO+2,   1, 1'b1);
    vecs[13] = mk(1'b0, 16'h5000, 8'h00, 2,    0, 8'h42, 8'h42, 4'h5, 5,      1, 1'b1);
    vecs[14] = mk(1'b0, 16'h6000, 8'h00, TO,   0, 8'h99, 8'hFF, 4'h5, TO+2,   1, 1'b1);
    // After the reset-during-WAIT sequence: all state back at reset values.
    vecs[15] = mk(1'b1, 16'hD020, 8'h0C, 1,    0, 8'h66, 8'h00, 4'hC, 4,      1, 1'b0);
    vecs[16] = mk(1'b0, 16'h7000, 8'h00, 2,    0, 8'h3E, 8'h3E, 4'hC, 5,      1, 1'b0);

    // Reset held with a read already on the bus.
    reset = 1'b1; cpu_ab = 16'h0100; cpu_do = 8'h00; cpu_we = 1'b0;
    mem_busy = 1'b0; mem_rdata = 8'h6B;
    repeat (3) @(negedge clk);
    chk("rst_cpu_di",   {24'd0, cpu_di},       32'h00);
    chk("rst_cpu_rdy",  {31'd0, cpu_rdy},      32'd0);
    chk("rst_mem_ce",   {31'd0, mem_ce},       32'd0);
    chk("rst_mem_write",{31'd0, mem_write},    32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr},     32'h0);
    chk("rst_mem_wdata",{24'd0, mem_wdata},    32'h0);
    chk("rst_nbytes",   {28'd0, mem_nbytes},   32'd1);
    chk("rst_border",   {28'd0, border_color}, 32'h0);
    chk("rst_bus_err",  {31'd0, bus_err},      32'd0);

    // Release in the middle of a cycle; the first access starts from here.
    reset = 1'b0;
    #1;
    chk("release_mem_ce", {31'd0, mem_ce}, 32'd0);
    @(negedge clk);
    #0;
    // Step back to this falling edge's context: vector 0 expects to be
    // entered in an IDLE cycle, so re-enter reset briefly to realign.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i <= 14; i++) apply_vec(i);

    // Reset asserted while an access is in WAIT (border write in flight).
    cpu_we = 1'b1; cpu_ab = 16'hD020; cpu_do = 8'h0A; mem_rdata = 8'h00;
    saw_ce = 0;
    for (int n = 0; n < 5 && !saw_ce; n++) begin
      @(negedge clk);
      if (mem_ce) saw_ce = 1;
    end
    chk("wrst_ce_seen", {31'd0, saw_ce}, 32'd1);
    @(negedge clk); mem_busy = 1'b1;
    @(negedge clk); mem_busy = 1'b1;
    reset = 1'b1;
    #1;
    chk("wrst_mem_ce",  {31'd0, mem_ce},       32'd0);
    chk("wrst_cpu_rdy", {31'd0, cpu_rdy},      32'd0);
    chk("wrst_border",  {28'd0, border_color}, 32'h0);
    chk("wrst_bus_err", {31'd0, bus_err},      32'd0);
    mem_busy = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk($sformatf("wrst_hold%0d_rdy", n), {31'd0, cpu_rdy | mem_ce}, 32'd0);
      chk($sformatf("wrst_hold%0d_border", n), {28'd0, border_color}, 32'h0);
    end
    reset = 1'b0;

    for (int i = 15; i < NV; i++) apply_vec(i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
